// File: rtl/ghost_nav_ctrl.sv
// Tile-map ghost navigation: scores the four neighbour tiles over four cycles, then
// commits a single tile move per accepted step request.
//
// state   | meaning
// S_IDLE  | waiting for step; latches mode, effective target and rotation seed
// S_EVAL0 | examine candidate up
// S_EVAL1 | examine candidate left
// S_EVAL2 | examine candidate down
// S_EVAL3 | examine candidate right, resolve the move and load the new tile
// S_COMMIT| new position visible, done pulse, last_mode updated
module ghost_nav_ctrl #(
    parameter int         TILE_SIZE   = 20,
    parameter int         COLS        = 32,
    parameter int         ROWS        = 24,
    parameter int         START_COL   = 30,
    parameter int         START_ROW   = 8,
    parameter logic [1:0] START_DIR   = 2'd0,
    parameter int         SCATTER_COL = 31,
    parameter int         SCATTER_ROW = 0,
    parameter int         WRAP_EN     = 0,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              step,
    input  logic [1:0]                        mode,
    input  logic [$clog2(COLS)-1:0]           target_col,
    input  logic [$clog2(ROWS)-1:0]           target_row,
    input  logic [ROWS*COLS-1:0]              tilemap_walls,
    output logic [$clog2(COLS*TILE_SIZE)-1:0] x,
    output logic [$clog2(ROWS*TILE_SIZE)-1:0] y,
    output logic [1:0]                        ghost_direction,
    output logic                              busy,
    output logic                              done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int XW = $clog2(COLS*TILE_SIZE);
    localparam int YW = $clog2(ROWS*TILE_SIZE);
    localparam int IW = $clog2(ROWS*COLS);
    localparam int DW = (CW > RW) ? CW : RW;
    localparam int SW = 2*DW + 1;

    localparam logic [1:0] MODE_SCATTER = 2'd1;
    localparam logic [1:0] MODE_FRIGHT  = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3, S_COMMIT
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } tile_t;

    // Off-grid neighbours come back invalid, which callers treat as wall.
    function automatic tile_t neighbour(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                        input logic [1:0] d);
        tile_t t;
        t.valid = 1'b1;
        t.col   = c;
        t.row   = r;
        case (d)
            DIR_UP:   if (r == '0) t.valid = 1'b0; else t.row = r - 1'b1;
            DIR_DOWN: if (r == RW'(ROWS-1)) t.valid = 1'b0; else t.row = r + 1'b1;
            DIR_LEFT: begin
                if (c == '0) begin
                    if (WRAP_EN != 0) t.col = CW'(COLS-1);
                    else t.valid = 1'b0;
                end else begin
                    t.col = c - 1'b1;
                end
            end
            default: begin
                if (c == CW'(COLS-1)) begin
                    if (WRAP_EN != 0) t.col = '0;
                    else t.valid = 1'b0;
                end else begin
                    t.col = c + 1'b1;
                end
            end
        endcase
        return t;
    endfunction

    state_t        state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    dir;
    logic [7:0]    lfsr;
    logic [1:0]    last_mode, mode_q, rot_q;
    logic [CW-1:0] tcol_q;
    logic [RW-1:0] trow_q;
    logic          acc_found, acc_found_nx;
    logic [1:0]    acc_dir, acc_dir_nx;
    logic [SW-1:0] acc_score, acc_score_nx;
    logic          rev_ok, rev_ok_nx;

    logic [1:0]    eval_idx, cand_dir, rev_dir, move_dir;
    tile_t         cand, move_tile;
    logic [IW-1:0] cand_idx;
    logic          cand_tile_ok, cand_is_rev, cand_open, mode_chg, move;
    logic [CW-1:0] dx_c;
    logic [RW-1:0] dy_r;
    logic [DW-1:0] dx, dy;
    logic [SW-1:0] score;

    assign ghost_direction = dir;
    assign rev_dir         = dir ^ 2'd1;

    always_comb begin
        eval_idx = 2'd0;
        case (state)
            S_EVAL1: eval_idx = 2'd1;
            S_EVAL2: eval_idx = 2'd2;
            S_EVAL3: eval_idx = 2'd3;
            default: eval_idx = 2'd0;
        endcase
        case (eval_idx)
            2'd0:    cand_dir = DIR_UP;
            2'd1:    cand_dir = DIR_LEFT;
            2'd2:    cand_dir = DIR_DOWN;
            default: cand_dir = DIR_RIGHT;
        endcase
    end

    always_comb begin
        cand         = neighbour(col, row, cand_dir);
        cand_idx     = IW'(cand.row) * IW'(COLS) + IW'(cand.col);
        cand_tile_ok = cand.valid && !tilemap_walls[cand_idx];
        cand_is_rev  = (cand_dir == rev_dir);
        cand_open    = cand_tile_ok && !cand_is_rev;
        dx_c         = (cand.col >= tcol_q) ? cand.col - tcol_q : tcol_q - cand.col;
        dy_r         = (cand.row >= trow_q) ? cand.row - trow_q : trow_q - cand.row;
        dx           = DW'(dx_c);
        dy           = DW'(dy_r);
        // Frightened reuses the min-search: distance from rot in rotation order.
        if (mode_q == MODE_FRIGHT) score = SW'(eval_idx - rot_q);
        else                       score = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
    end

    always_comb begin
        acc_found_nx = acc_found;
        acc_dir_nx   = acc_dir;
        acc_score_nx = acc_score;
        rev_ok_nx    = rev_ok;
        if (cand_open && (!acc_found || score < acc_score)) begin
            acc_found_nx = 1'b1;
            acc_dir_nx   = cand_dir;
            acc_score_nx = score;
        end
        if (cand_is_rev) rev_ok_nx = cand_tile_ok;
    end

    // Resolved in EVAL3 using the accumulator values that include the last candidate.
    always_comb begin
        mode_chg = (mode_q != last_mode) && (mode_q != MODE_HOLD) && (last_mode != MODE_HOLD);
        move     = 1'b0;
        move_dir = dir;
        if (mode_q != MODE_HOLD) begin
            if (mode_chg && rev_ok_nx) begin
                move     = 1'b1;
                move_dir = rev_dir;
            end else if (acc_found_nx) begin
                move     = 1'b1;
                move_dir = acc_dir_nx;
            end else if (rev_ok_nx) begin
                move     = 1'b1;
                move_dir = rev_dir;
            end
        end
        move_tile = neighbour(col, row, move_dir);
    end

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = (state == S_COMMIT);
        case (state)
            S_IDLE:   if (step) state_nx = S_EVAL0;
            S_EVAL0:  state_nx = S_EVAL1;
            S_EVAL1:  state_nx = S_EVAL2;
            S_EVAL2:  state_nx = S_EVAL3;
            S_EVAL3:  state_nx = S_COMMIT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= CW'(START_COL);
            row       <= RW'(START_ROW);
            x         <= XW'(START_COL*TILE_SIZE);
            y         <= YW'(START_ROW*TILE_SIZE);
            dir       <= START_DIR;
            lfsr      <= LFSR_SEED;
            last_mode <= 2'd0;
            mode_q    <= 2'd0;
            rot_q     <= 2'd0;
            tcol_q    <= '0;
            trow_q    <= '0;
            acc_found <= 1'b0;
            acc_dir   <= 2'd0;
            acc_score <= '0;
            rev_ok    <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                S_IDLE: begin
                    if (step) begin
                        mode_q    <= mode;
                        rot_q     <= lfsr[1:0];
                        acc_found <= 1'b0;
                        rev_ok    <= 1'b0;
                        if (mode == MODE_SCATTER) begin
                            tcol_q <= CW'(SCATTER_COL);
                            trow_q <= RW'(SCATTER_ROW);
                        end else begin
                            tcol_q <= target_col;
                            trow_q <= target_row;
                        end
                    end
                end
                S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3: begin
                    acc_found <= acc_found_nx;
                    acc_dir   <= acc_dir_nx;
                    acc_score <= acc_score_nx;
                    rev_ok    <= rev_ok_nx;
                    if (state == S_EVAL3) begin
                        dir <= move_dir;
                        if (move && move_tile.valid) begin
                            col <= move_tile.col;
                            row <= move_tile.row;
                            x   <= XW'(int'(move_tile.col) * TILE_SIZE);
                            y   <= YW'(int'(move_tile.row) * TILE_SIZE);
                        end
                    end
                end
                S_COMMIT: last_mode <= mode_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_nav_ctrl.sv
// Bench for ghost_nav_ctrl: directed vector table, hand-built corner sequences and a
// randomized walk checked against a tile-level reference model.
module tb_ghost_nav_ctrl;

    localparam int C  = 32;
    localparam int R  = 24;
    localparam int TS = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         step, step_t;
    logic [1:0]   mode;
    logic [4:0]   target_col, target_row;
    logic [767:0] walls;

    logic [9:0] x, x_w, x_n;
    logic [8:0] y, y_w, y_n;
    logic [1:0] gdir, gdir_w, gdir_n;
    logic       busy, busy_w, busy_n;
    logic       done, done_w, done_n;

    always #5 clk = ~clk;

    ghost_nav_ctrl dut (
        .clk(clk), .reset(reset), .step(step), .mode(mode),
        .target_col(target_col), .target_row(target_row), .tilemap_walls(walls),
        .x(x), .y(y), .ghost_direction(gdir), .busy(busy), .done(done));

    ghost_nav_ctrl #(.START_COL(0), .START_ROW(12), .START_DIR(2'd2), .WRAP_EN(1)) dut_wrap (
        .clk(clk), .reset(reset), .step(step_t), .mode(mode),
        .target_col(target_col), .target_row(target_row), .tilemap_walls(walls),
        .x(x_w), .y(y_w), .ghost_direction(gdir_w), .busy(busy_w), .done(done_w));

    ghost_nav_ctrl #(.START_COL(0), .START_ROW(12), .START_DIR(2'd2), .WRAP_EN(0)) dut_nowrap (
        .clk(clk), .reset(reset), .step(step_t), .mode(mode),
        .target_col(target_col), .target_row(target_row), .tilemap_walls(walls),
        .x(x_n), .y(y_n), .ghost_direction(gdir_n), .busy(busy_n), .done(done_n));

    int tests = 0;
    int fails = 0;

    logic [7:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    int m_col, m_row, m_dir, m_last;

    typedef struct {
        int         md;
        logic [3:0] mask;
        int         dc, dr;
        int         ex_dc, ex_dr, ex_dir;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit tile_open(input int c, input int r, input int d, input int wrap,
                                     input logic [767:0] w, output int oc, output int orr);
        oc  = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        orr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        if (wrap != 0) begin
            if (oc < 0) oc = C - 1;
            else if (oc >= C) oc = 0;
        end
        if (oc < 0 || oc >= C || orr < 0 || orr >= R) return 1'b0;
        return !w[orr*C + oc];
    endfunction

    function automatic void model_step(input int c, input int r, input int d, input int lm,
                                       input int md, input int tc, input int tr, input int rot,
                                       input logic [767:0] w, input int wrap,
                                       output int nc, output int nr, output int nd);
        int pri[4] = '{0, 2, 1, 3};
        int rev, rc, rr, oc, orr, best, bc, br, best_sc, sc, k;
        bit rev_ok;
        nc = c; nr = r; nd = d;
        rev = d ^ 1;
        rev_ok = tile_open(c, r, rev, wrap, w, rc, rr);
        if (md == 3) return;
        if (md != lm && lm != 3 && rev_ok) begin
            nc = rc; nr = rr; nd = rev;
            return;
        end
        best = -1; bc = c; br = r; best_sc = 0;
        for (int j = 0; j < 4; j++) begin
            k = (md == 2) ? (rot + j) % 4 : j;
            if (pri[k] == rev) continue;
            if (!tile_open(c, r, pri[k], wrap, w, oc, orr)) continue;
            sc = (oc - tc) * (oc - tc) + (orr - tr) * (orr - tr);
            if (best < 0 || (md != 2 && sc < best_sc)) begin
                best = pri[k]; bc = oc; br = orr; best_sc = sc;
            end
        end
        if (best >= 0) begin
            nc = bc; nr = br; nd = best;
        end else if (rev_ok) begin
            nc = rc; nr = rr; nd = rev;
        end
    endfunction

    task automatic set_walls(input int c, input int r, input logic [3:0] mask);
        int oc, orr;
        walls = '0;
        for (int d = 0; d < 4; d++)
            if (mask[d] && tile_open(c, r, d, 0, '0, oc, orr)) walls[orr*C + oc] = 1'b1;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_step(input string tag, input int md, input int tc, input int tr,
                            input int ec, input int er, input int ed);
        int lat;
        mode = 2'(md); target_col = 5'(tc); target_row = 5'(tr);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_x"}, x, ec*TS);
        check({tag, "_y"}, y, er*TS);
        check({tag, "_dir"}, gdir, ed);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, 0);
    endtask

    initial begin
        int tc, tr, nc, nr, nd, md, rot, dcount, lat;
        reset = 1'b1; step = 1'b0; step_t = 1'b0; mode = 2'd0;
        target_col = '0; target_row = '0; walls = '0;
        tbl[0]  = '{0, 4'b0011, -20,  0, -1,  0, 2};
        tbl[1]  = '{0, 4'b0011,   2,  0, -1,  0, 2};
        tbl[2]  = '{0, 4'b0000,  -1, -1,  0, -1, 0};
        tbl[3]  = '{0, 4'b0000,  -5,  0, -1,  0, 2};
        tbl[4]  = '{0, 4'b0111,   0,  0,  1,  0, 3};
        tbl[5]  = '{0, 4'b1111,   0,  0,  0,  0, 3};
        tbl[6]  = '{3, 4'b0000,   0,  0,  0,  0, 3};
        tbl[7]  = '{0, 4'b0000, -10,  0,  0, -1, 0};
        tbl[8]  = '{1, 4'b0000,   0,  0,  0,  1, 1};
        tbl[9]  = '{1, 4'b0000,   0,  0,  1,  0, 3};
        tbl[10] = '{0, 4'b0100,   0,  3,  0,  1, 1};
        tbl[11] = '{2, 4'b0000,   0,  0,  0, -1, 0};
        tbl[12] = '{2, 4'b0101,   0,  0,  1,  0, 3};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_x", x, 600);
        check("reset_y", y, 160);
        check("reset_dir", gdir, 0);
        check("reset_busy_done", {busy, done}, 0);
        check("reset_wrap_pos", {x_w, y_w, gdir_w}, {10'd0, 9'd240, 2'd2});
        m_col = 30; m_row = 8; m_dir = 0; m_last = 0;

        for (int i = 0; i < 13; i++) begin
            tc = m_col + tbl[i].dc; tc = (tc < 0) ? 0 : (tc > C-1) ? C-1 : tc;
            tr = m_row + tbl[i].dr; tr = (tr < 0) ? 0 : (tr > R-1) ? R-1 : tr;
            set_walls(m_col, m_row, tbl[i].mask);
            run_step($sformatf("vec%0d", i), tbl[i].md, tc, tr,
                     m_col + tbl[i].ex_dc, m_row + tbl[i].ex_dr, tbl[i].ex_dir);
            m_col += tbl[i].ex_dc; m_row += tbl[i].ex_dr; m_dir = tbl[i].ex_dir;
            m_last = tbl[i].md;
        end

        // A second step while busy must be dropped, leaving a single move and done pulse.
        walls = '0; mode = 2'd0; target_col = 5'd0; target_row = 5'd0;
        model_step(m_col, m_row, m_dir, m_last, 0, 0, 0, 0, walls, 0, nc, nr, nd);
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ignored_step_done_count", dcount, 1);
        check("ignored_step_pos", {x, y, gdir}, {10'(nc*TS), 9'(nr*TS), 2'(nd)});
        check("ignored_step_busy", busy, 0);
        m_col = nc; m_row = nr; m_dir = nd; m_last = 0;

        // Asynchronous reset landing in the middle of EVAL2.
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_x", x, 600);
        check("midreset_y", y, 160);
        check("midreset_dir", gdir, 0);
        check("midreset_busy", busy, 0);
        @(negedge clk); reset = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midreset_no_done", dcount, 0);
        check("midreset_pos_held", {x, y, gdir}, {10'd600, 9'd160, 2'd0});
        m_col = 30; m_row = 8; m_dir = 0; m_last = 0;

        // Tunnel: wrap instance crosses to column 31, non-wrap instance hits a dead end.
        walls = '0; walls[11*C] = 1'b1; walls[13*C] = 1'b1;
        mode = 2'd0; target_col = 5'd31; target_row = 5'd12;
        step_t = 1'b1;
        @(negedge clk); step_t = 1'b0;
        lat = 1;
        while (!done_w && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("tunnel_latency", lat, 5);
        check("tunnel_wrap_x", x_w, 620);
        check("tunnel_wrap_y", y_w, 240);
        check("tunnel_wrap_dir", gdir_w, 2);
        check("tunnel_nowrap_done", done_n, 1);
        check("tunnel_nowrap_x", x_n, 20);
        check("tunnel_nowrap_dir", gdir_n, 3);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            for (int b = 0; b < C*R; b++) walls[b] = ($urandom_range(0, 3) == 0);
            md  = int'($urandom_range(0, 3));
            tc  = int'($urandom_range(0, C-1));
            tr  = int'($urandom_range(0, R-1));
            rot = int'(m_lfsr[1:0]);
            model_step(m_col, m_row, m_dir, m_last, md,
                       (md == 1) ? 31 : tc, (md == 1) ? 0 : tr, rot, walls, 0, nc, nr, nd);
            run_step($sformatf("rand%0d", n), md, tc, tr, nc, nr, nd);
            m_col = nc; m_row = nr; m_dir = nd; m_last = md;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
